// File: rtl/traffic_phase_sched.sv
// Round-robin phase scheduler for the traffic light datapath: latches requests, issues
// one phase per valid/ready handshake, then waits for phase_done plus an all-red gap.
// Define SCHED_AGING_EN to build per-requester age counters and starvation priority.
module traffic_phase_sched #(
   parameter int unsigned ALL_RED  = 3,
   parameter int unsigned MAX_WAIT = 60,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       cmd_ready,
   input  logic       phase_done,
   output logic       cmd_valid,
   output logic [1:0] cmd_phase,
   output logic       busy,
   output logic [3:0] pending,
   output logic       starve
);

   // ALL_RED of 0 is treated as a single clearance cycle.
   localparam logic [CNT_W-1:0] CLR_LOAD = (ALL_RED == 0) ? '0 : CNT_W'(ALL_RED - 1);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, CLEAR} state_t;

   state_t           state, state_nxt;
   logic             cmd_valid_nxt;
   logic [1:0]       cmd_phase_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;
   logic             accept;
   logic [3:0]       clr_mask;
   logic [3:0]       pending_nxt;
   logic [1:0]       rr_sel;
   logic [1:0]       rr_idx;
   logic [1:0]       win_sel;

   assign accept      = (state == GRANT) && cmd_valid && cmd_ready;
   assign clr_mask    = accept ? (4'b0001 << cmd_phase) : '0;
   assign pending_nxt = (pending & ~clr_mask) | req;
   assign busy        = (state != IDLE);

   // Scan from ptr+4 (ptr itself) down to ptr+1 so the nearest set bit after ptr is kept.
   always_comb begin
      rr_sel = ptr;
      rr_idx = ptr;
      for (int unsigned k = 4; k > 0; k--) begin
         rr_idx = ptr + 2'(k);
         if (pending[rr_idx]) rr_sel = rr_idx;
      end
   end

`ifdef SCHED_AGING_EN
   logic [CNT_W-1:0] age [4];
   logic [3:0]       old_flag;
   logic [1:0]       age_sel;
   logic             age_hit;

   always_comb begin
      old_flag = '0;
      age_sel  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         old_flag[i] = pending[i] && (32'(age[i]) >= MAX_WAIT);
      end
      for (int unsigned i = 4; i > 0; i--) begin
         if (old_flag[i-1]) age_sel = 2'(i - 1);
      end
      age_hit = |old_flag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++) age[i] <= '0;
         starve <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (!pending[i] || clr_mask[i]) age[i] <= '0;
            else if (age[i] != '1)           age[i] <= age[i] + CNT_W'(1);
         end
         starve <= age_hit;
      end
   end

   assign win_sel = age_hit ? age_sel : rr_sel;
`else
   logic unused_cfg;

   assign unused_cfg = ^(32'(MAX_WAIT));
   assign starve     = 1'b0;
   assign win_sel    = rr_sel;
`endif

   always_comb begin
      state_nxt     = state;
      cmd_valid_nxt = cmd_valid;
      cmd_phase_nxt = cmd_phase;
      ptr_nxt       = ptr;
      clr_cnt_nxt   = clr_cnt;
      case (state)
         IDLE: begin
            if (pending != '0) begin
               cmd_phase_nxt = win_sel;
               cmd_valid_nxt = 1'b1;
               state_nxt     = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               ptr_nxt       = cmd_phase;
               cmd_valid_nxt = 1'b0;
               state_nxt     = BUSY;
            end
         end
         BUSY: begin
            if (phase_done) begin
               clr_cnt_nxt = CLR_LOAD;
               state_nxt   = CLEAR;
            end
         end
         CLEAR: begin
            if (clr_cnt == '0) state_nxt = IDLE;
            else               clr_cnt_nxt = clr_cnt - CNT_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_valid <= 1'b0;
         cmd_phase <= '0;
         ptr       <= 2'd3;
         clr_cnt   <= '0;
         pending   <= '0;
      end else begin
         state     <= state_nxt;
         cmd_valid <= cmd_valid_nxt;
         cmd_phase <= cmd_phase_nxt;
         ptr       <= ptr_nxt;
         clr_cnt   <= clr_cnt_nxt;
         pending   <= pending_nxt;
      end
   end

endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

Phase scheduler sitting in front of the `traffic` light controller datapath. It latches service requests from four approach groups (NS through, EW through, NS left-turn, EW left-turn), picks the next phase with round-robin arbitration, and issues it to the light datapath over a valid/ready command handshake. It then waits for phase completion and enforces an all-red clearance gap before arbitrating again.

## Interface
- `ALL_RED`, default 3: clearance cycles after `phase_done` before the next arbitration. A value of 0 behaves as 1.
- `MAX_WAIT`, default 60: wait-age threshold in cycles for starvation priority (only with `SCHED_AGING_EN`).
- `CNT_W`, default 8: width of the age and clearance counters.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: level service requests. Bit 0 = NS through, 1 = EW through, 2 = NS left, 3 = EW left.
- `cmd_ready` in 1: datapath is idle (all-red) and can accept a phase.
- `phase_done` in 1: single-cycle pulse from the datapath when the granted phase (including yellow) has finished.
- `cmd_valid` out 1: phase command offered.
- `cmd_phase` out 2: index of the phase being commanded.
- `busy` out 1: high in states GRANT, BUSY and CLEAR.
- `pending` out 4: latched, unserved requests.
- `starve` out 1: some pending requester has age ≥ `MAX_WAIT`. Tied to 0 without `SCHED_AGING_EN`.

## Operation
- States: IDLE, GRANT, BUSY, CLEAR.
- `pending` update each cycle: `pending <= (pending & ~clr) | req`.
  - `clr` is one-hot for `cmd_phase`, asserted only on the accept cycle (`cmd_valid && cmd_ready`).
  - A `req` that is high on the accept cycle re-latches its bit.
- IDLE, with `pending != 0`:
  - Select the first set bit searching from `ptr+1` upward, wrapping at 3→0.
  - Register the result into `cmd_phase`, set `cmd_valid = 1`, go to GRANT.
- IDLE, with `pending == 0`: stay in IDLE; `cmd_phase` holds its value.
- GRANT:
  - Hold `cmd_valid` and `cmd_phase` stable until accept.
  - On accept: `ptr <= cmd_phase`, `cmd_valid <= 0`, go to BUSY.
- BUSY: on `phase_done`, load the clearance counter with `max(ALL_RED,1) - 1` and go to CLEAR.
- CLEAR: decrement the counter; when it reads 0, go to IDLE.
- `phase_done` outside BUSY is ignored.
- `cmd_ready` outside GRANT is ignored.
- New requests arriving during GRANT, BUSY or CLEAR are latched but do not change the command in flight.

## Timing
- Reset values: state IDLE, `cmd_valid` 0, `cmd_phase` 0, `pending` 0, `busy` 0, `starve` 0, `ptr` 3 (so requester 0 wins first), all ages 0, clearance counter 0.
- Reset asserted mid-operation: every register above returns to its reset value on the next edge, and any in-flight command is dropped.
- Latency, request to offer: `req` first sampled at edge t → `pending` set after t → `cmd_valid` high after edge t+1.
- With `cmd_ready` held high, accept occurs at edge t+2.
- Gap: `phase_done` sampled at edge d → IDLE after edge d + max(ALL_RED,1) → next `cmd_valid` one edge later if a request is pending.
- Back-to-back `phase_done` pulses: only the first one in BUSY has effect.
- `cmd_phase` never changes while `cmd_valid` = 1.

## Configuration
- `SCHED_AGING_EN` defined:
  - Per-requester `age[i]` (CNT_W bits) increments each cycle while `pending[i]` is set and `i` is not the accepted phase, saturating at all-ones.
  - `age[i]` clears when `pending[i]` is 0 or on its accept.
  - In IDLE, if any `age[i] >= MAX_WAIT`, the lowest such index wins over round-robin; `ptr` still updates to the granted index.
  - `starve` is the registered OR of the threshold compares.
- `SCHED_AGING_EN` undefined:
  - No age counters are built; arbitration is pure round-robin.
  - `starve` is constant 0.

## Test plan
- Reset, then `req`=4'b0001 pulsed for 1 cycle with `cmd_ready`=1 → `cmd_valid` high 2 cycles after the sample with `cmd_phase`=0, accepted next edge, `pending`=0, `busy`=1.
- `req`=4'b1111 held, `cmd_ready`=1, `phase_done` pulsed 5 cycles after each accept, ALL_RED=3 → grants 0,1,2,3,0 in order; exactly 3 CLEAR cycles between `phase_done` and the return to IDLE.
- `cmd_ready`=0 for 10 cycles during GRANT while `req` toggles → `cmd_valid` and `cmd_phase` stay constant; accepted on the first `cmd_ready`=1.
- `rst`=1 for 1 cycle while in BUSY with `pending`=4'b0110 → next cycle state IDLE, `pending`=0, `cmd_valid`=0, `busy`=0; the next grant with `req`=4'b0001 is phase 0.
- `phase_done` pulsed in IDLE and GRANT → no state change.
- With `SCHED_AGING_EN`, MAX_WAIT=10: hold `req[3]` while phases 0–2 cycle continuously, each lasting 20 cycles → `starve`=1 once `age[3]` reaches 10; the next grant is phase 3 even though `ptr`=0.
